// File: rtl/wbuf_pkg.sv
// Shared types for the write-buffer drain: the FIFO entry layout and its width.
package wbuf_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_BE_W   = WB_DATA_W / 8;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_BE_W-1:0]   be;
    logic [WB_DATA_W-1:0] data;
  } wbuf_entry_t;

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w / 8 + data_w;
  endfunction

endpackage

// File: rtl/wbuf_drain.sv
// Drains the cache write-buffer FIFO into memory write requests, tracking
// outstanding writes so the cache controller can order flushes and fences.
module wbuf_drain
  import wbuf_pkg::*;
#(
  parameter int ADDR_WIDTH      = WB_ADDR_W,
  parameter int DATA_WIDTH      = WB_DATA_W,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rstn_i,
  input  logic [ADDR_WIDTH+DATA_WIDTH/8+DATA_WIDTH-1:0] fifo_data_i,
  input  logic                                         fifo_empty_i,
  output logic                                         fifo_pop_o,
  output logic                                         mem_req_o,
  input  logic                                         mem_gnt_i,
  output logic                                         mem_we_o,
  output logic [ADDR_WIDTH-1:0]                        mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]                      mem_be_o,
  output logic [DATA_WIDTH-1:0]                        mem_wdata_o,
  input  logic                                         mem_rvalid_i,
  input  logic                                         mem_err_i,
  input  logic                                         hold_i,
  input  logic                                         err_clr_i,
  output logic                                         idle_o,
  output logic                                         err_o
);

  localparam int ENT_W = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W:0] MAX_OUT = (CNT_W + 1)'(MAX_OUTSTANDING);

  logic             req_valid_q, req_valid_d;
  logic [ENT_W-1:0] entry_q, entry_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             err_q, err_d;

  logic             load;
  logic             gnt;
  logic             spurious;
  logic [CNT_W:0]   inflight;

  // A held request counts against the outstanding budget before it is granted,
  // so the counter can never overflow once that request is accepted.
  assign inflight = {1'b0, outst_q} + {{CNT_W{1'b0}}, req_valid_q};
  assign load     = rstn_i & ~fifo_empty_i & ~hold_i & (~req_valid_q | mem_gnt_i)
                  & (inflight < MAX_OUT);
  assign gnt      = req_valid_q & mem_gnt_i;
  assign spurious = mem_rvalid_i & ~gnt & (outst_q == '0);

  always_comb begin
    req_valid_d = req_valid_q;
    entry_d     = entry_q;
    if (load) begin
      req_valid_d = 1'b1;
      entry_d     = fifo_data_i;
    end else if (gnt) begin
      req_valid_d = 1'b0;
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (gnt & ~mem_rvalid_i) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (~gnt & mem_rvalid_i & (outst_q != '0)) begin
      outst_d = outst_q - CNT_W'(1);
    end
  end

  // A new error wins over a simultaneous clear so no error report is lost.
  always_comb begin
    err_d = err_q;
    if ((mem_rvalid_i & mem_err_i) | spurious) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      req_valid_q <= 1'b0;
      entry_q     <= '0;
      outst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      entry_q     <= entry_d;
      outst_q     <= outst_d;
      err_q       <= err_d;
    end
  end

  assign fifo_pop_o = load;
  assign mem_req_o  = req_valid_q;
  assign mem_we_o   = req_valid_q;
  assign {mem_addr_o, mem_be_o, mem_wdata_o} = entry_q;
  assign idle_o     = fifo_empty_i & ~req_valid_q & (outst_q == '0);
  assign err_o      = err_q;

endmodule

// File: tb/tb_wbuf_drain.sv
// Self-checking bench for wbuf_drain: a queue-based FIFO/memory model predicts
// every output each cycle, backed by hand-computed scenario checks.
module tb_wbuf_drain;
  import wbuf_pkg::*;

  localparam int ENT_W = entry_width(WB_ADDR_W, WB_DATA_W);
  localparam int MAXO  = 2;

  logic                 clk_i        = 1'b0;
  logic                 rstn_i       = 1'b0;
  logic [ENT_W-1:0]     fifo_data_i  = '0;
  logic                 fifo_empty_i = 1'b1;
  logic                 fifo_pop_o;
  logic                 mem_req_o;
  logic                 mem_gnt_i    = 1'b0;
  logic                 mem_we_o;
  logic [WB_ADDR_W-1:0] mem_addr_o;
  logic [WB_BE_W-1:0]   mem_be_o;
  logic [WB_DATA_W-1:0] mem_wdata_o;
  logic                 mem_rvalid_i = 1'b0;
  logic                 mem_err_i    = 1'b0;
  logic                 hold_i       = 1'b0;
  logic                 err_clr_i    = 1'b0;
  logic                 idle_o;
  logic                 err_o;

  wbuf_drain #(
    .ADDR_WIDTH(WB_ADDR_W),
    .DATA_WIDTH(WB_DATA_W),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .hold_i(hold_i), .err_clr_i(err_clr_i), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference state: the FIFO contents, the one request waiting for a grant,
  // how many granted writes still await completion, and the sticky error.
  wbuf_entry_t fifoQ[$];
  wbuf_entry_t pushLog[$];
  wbuf_entry_t grantLog[$];
  bit          pendValid = 1'b0;
  wbuf_entry_t pendEnt   = '0;
  int          outst     = 0;
  bit          errM      = 1'b0;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  bit cmpEn    = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit expLoad();
    return (fifoQ.size() > 0) && !hold_i && (!pendValid || mem_gnt_i)
           && (outst + int'(pendValid) < MAXO);
  endfunction

  initial begin : modelProc
    bit ld, g, rv;
    forever begin
      @(posedge clk_i or negedge rstn_i);
      if (!rstn_i) begin
        fifoQ.delete();
        pushLog.delete();
        grantLog.delete();
        pendValid = 1'b0;
        pendEnt   = '0;
        outst     = 0;
        errM      = 1'b0;
      end else begin
        ld = expLoad();
        g  = pendValid && mem_gnt_i;
        rv = mem_rvalid_i;
        if (rv && (mem_err_i || (outst == 0 && !g))) errM = 1'b1;
        else if (err_clr_i) errM = 1'b0;
        outst = outst + int'(g) - int'(rv);
        if (outst < 0) outst = 0;
        if (g) grantLog.push_back(pendEnt);
        if (ld) begin
          pendEnt   = fifoQ.pop_front();
          pendValid = 1'b1;
        end else if (g) begin
          pendValid = 1'b0;
        end
      end
    end
  end

  // The FIFO head is presented shortly after each edge, once model and pushes settle.
  initial begin : fifoDriver
    forever begin
      @(posedge clk_i or negedge rstn_i);
      #2;
      fifo_empty_i = (fifoQ.size() == 0);
      fifo_data_i  = (fifoQ.size() > 0) ? fifoQ[0] : '0;
    end
  end

  // Memory agent: mode 1 completes each write in its grant cycle, mode 2 is random.
  initial begin : memAgent
    forever begin
      @(posedge clk_i);
      #1;
      if (mode == 1) begin
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = pendValid || (outst > 0);
        mem_err_i    = 1'b0;
      end else if (mode == 2) begin
        mem_gnt_i    = ($urandom % 4) != 0;
        mem_rvalid_i = (outst > 0) ? (($urandom % 2) == 1) : (($urandom % 50) == 0);
        mem_err_i    = mem_rvalid_i && (($urandom % 8) == 0);
      end
    end
  end

  initial begin : compareProc
    forever begin
      @(negedge clk_i);
      if (rstn_i && cmpEn) begin
        checkOutput("req", mem_req_o, pendValid);
        checkOutput("we", mem_we_o, pendValid);
        if (pendValid) begin
          checkOutput("addr", mem_addr_o, pendEnt.addr);
          checkOutput("be", mem_be_o, pendEnt.be);
          checkOutput("wdata", mem_wdata_o, pendEnt.data);
        end
        checkOutput("pop", fifo_pop_o, expLoad());
        checkOutput("idle", idle_o, (fifoQ.size() == 0) && !pendValid && (outst == 0));
        checkOutput("err", err_o, errM);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic atNeg();
    @(negedge clk_i);
  endtask

  task automatic pushEntry(input wbuf_entry_t e);
    fifoQ.push_back(e);
    pushLog.push_back(e);
  endtask

  function automatic wbuf_entry_t randEntry();
    wbuf_entry_t e;
    e.addr = $urandom;
    e.be   = WB_BE_W'($urandom);
    e.data = $urandom;
    return e;
  endfunction

  task automatic drainAll();
    int n = 0;
    bit ok;
    mode      = 1;
    hold_i    = 1'b0;
    err_clr_i = 1'b0;
    while ((fifoQ.size() > 0 || pendValid || outst > 0) && n < 300) begin
      tick();
      n++;
    end
    checkOutput("drain_timeout", n < 300, 1);
    ok = (grantLog.size() == pushLog.size());
    for (int i = 0; i < grantLog.size() && ok; i++) begin
      if (grantLog[i] !== pushLog[i]) ok = 1'b0;
    end
    checkOutput("drain_order", ok, 1);
    mode = 0;
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
  endtask

  task automatic applyStimulus();
    wbuf_entry_t e;
    wbuf_entry_t eb;
    int grants, reqCnt, popCnt, firstReq, lastReq, maxOut;

    // Reset state
    repeat (2) tick();
    atNeg();
    checkOutput("rst_req", mem_req_o, 0);
    checkOutput("rst_idle", idle_o, 1);
    tick();
    rstn_i = 1'b1;
    atNeg();
    checkOutput("init_req", mem_req_o, 0);
    checkOutput("init_pop", fifo_pop_o, 0);
    checkOutput("init_err", err_o, 0);
    checkOutput("init_idle", idle_o, 1);
    cmpEn = 1'b1;

    // Single entry with exact payload
    tick();
    mem_gnt_i = 1'b1;
    e.addr = 32'h100; e.be = 4'hF; e.data = 32'hDEADBEEF;
    pushEntry(e);
    atNeg();
    checkOutput("t1_pop", fifo_pop_o, 1);
    checkOutput("t1_req0", mem_req_o, 0);
    tick();
    atNeg();
    checkOutput("t1_req", mem_req_o, 1);
    checkOutput("t1_addr", mem_addr_o, 32'h100);
    checkOutput("t1_be", mem_be_o, 4'hF);
    checkOutput("t1_wdata", mem_wdata_o, 32'hDEADBEEF);
    checkOutput("t1_pop2", fifo_pop_o, 0);
    tick();
    atNeg();
    checkOutput("t1_req_done", mem_req_o, 0);
    checkOutput("t1_busy", idle_o, 0);
    tick();
    mem_rvalid_i = 1'b1;
    atNeg();
    checkOutput("t1_busy2", idle_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    atNeg();
    checkOutput("t1_idle", idle_o, 1);

    // Eight back-to-back writes, completed in their grant cycle
    mode = 1;
    tick();
    for (int i = 0; i < 8; i++) pushEntry(randEntry());
    reqCnt = 0; popCnt = 0; firstReq = -1; lastReq = -1; maxOut = 0;
    for (int c = 0; c < 14; c++) begin
      atNeg();
      if (mem_req_o) begin
        reqCnt++;
        if (firstReq < 0) firstReq = c;
        lastReq = c;
      end
      if (fifo_pop_o) popCnt++;
      if (outst > maxOut) maxOut = outst;
      tick();
    end
    checkOutput("t2_reqs", reqCnt, 8);
    checkOutput("t2_contig", lastReq - firstReq + 1, 8);
    checkOutput("t2_pops", popCnt, 8);
    checkOutput("t2_maxout", maxOut <= 1, 1);
    drainAll();

    // Outstanding limit with completions withheld
    mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) pushEntry(randEntry());
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      atNeg();
      if (mem_req_o && mem_gnt_i) grants++;
      tick();
    end
    atNeg();
    checkOutput("t3_grants", grants, 2);
    checkOutput("t3_pop_blocked", fifo_pop_o, 0);
    checkOutput("t3_req_blocked", mem_req_o, 0);
    tick();
    mem_rvalid_i = 1'b1;
    atNeg();
    tick();
    mem_rvalid_i = 1'b0;
    atNeg();
    checkOutput("t3_pop_resume", fifo_pop_o, 1);
    drainAll();

    // Grant withheld: request and payload held stable
    e  = randEntry();
    eb = randEntry();
    pushEntry(e);
    pushEntry(eb);
    atNeg();
    checkOutput("t4_pop", fifo_pop_o, 1);
    tick();
    for (int s = 0; s < 5; s++) begin
      atNeg();
      checkOutput("t4_req_held", mem_req_o, 1);
      checkOutput("t4_addr_held", mem_addr_o, e.addr);
      checkOutput("t4_be_held", mem_be_o, e.be);
      checkOutput("t4_wdata_held", mem_wdata_o, e.data);
      checkOutput("t4_no_pop", fifo_pop_o, 0);
      tick();
    end
    mem_gnt_i = 1'b1;
    atNeg();
    checkOutput("t4_req_gnt", mem_req_o, 1);
    checkOutput("t4_pop_repl", fifo_pop_o, 1);
    tick();
    mem_gnt_i = 1'b0;
    atNeg();
    checkOutput("t4_next_addr", mem_addr_o, eb.addr);
    drainAll();

    // Error completion, clear, and spurious completion
    mem_gnt_i = 1'b1;
    pushEntry(randEntry());
    tick();
    tick();
    mem_gnt_i = 1'b0;
    tick();
    mem_rvalid_i = 1'b1;
    mem_err_i    = 1'b1;
    atNeg();
    checkOutput("t5_err_before", err_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    pushEntry(randEntry());
    atNeg();
    checkOutput("t5_err_set", err_o, 1);
    checkOutput("t5_still_pops", fifo_pop_o, 1);
    drainAll();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    atNeg();
    checkOutput("t5_err_clr", err_o, 0);
    tick();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    atNeg();
    checkOutput("t5_spurious_err", err_o, 1);
    checkOutput("t5_spurious_idle", idle_o, 1);
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;

    // Hold blocks pops, then drains in order
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) pushEntry(randEntry());
    for (int c = 0; c < 4; c++) begin
      atNeg();
      checkOutput("t6_hold_pop", fifo_pop_o, 0);
      checkOutput("t6_hold_idle", idle_o, 0);
      tick();
    end
    drainAll();

    // Reset in the middle of a burst
    mode = 1;
    tick();
    for (int i = 0; i < 6; i++) pushEntry(randEntry());
    tick();
    tick();
    tick();
    mode   = 0;
    rstn_i = 1'b0;
    #1;
    checkOutput("t6_rst_req", mem_req_o, 0);
    checkOutput("t6_rst_we", mem_we_o, 0);
    checkOutput("t6_rst_pop", fifo_pop_o, 0);
    checkOutput("t6_rst_err", err_o, 0);
    checkOutput("t6_rst_idle", idle_o, fifo_empty_i);
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    tick();
    rstn_i = 1'b1;
    atNeg();
    checkOutput("t6_after_rst_idle", idle_o, 1);
    tick();

    // Randomized traffic
    mode = 2;
    for (int c = 0; c < 500; c++) begin
      tick();
      hold_i    = ($urandom % 5) == 0;
      err_clr_i = ($urandom % 10) == 0;
      if (fifoQ.size() < 6 && ($urandom % 2) == 1) pushEntry(randEntry());
    end
    drainAll();
  endtask

  initial begin
    applyStimulus();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
